// File: rtl/memtest_memory_responder.sv
// Single-port word memory answering memTest initiators; completes writes after WRITE_LATENCY and reads after READ_LATENCY cycles.
// No backpressure beyond o_busy: requests are sampled only in idle, and anything arriving while busy is dropped.
module memtest_memory_responder #(
  parameter int DATUM_WIDTH   = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int WRITE_LATENCY = 1,
  parameter int READ_LATENCY  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_async,
  input  logic                   i_write_req,
  input  logic                   i_read_req,
  input  logic [ADDR_WIDTH-1:0]  i_address,
  input  logic [DATUM_WIDTH-1:0] i_write_data,
  input  logic [DATUM_WIDTH-1:0] i_fault_mask,
  output logic                   o_memory_write_ready,
  output logic                   o_memory_read_valid,
  output logic [DATUM_WIDTH-1:0] o_read_data,
  output logic                   o_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WR_CNT_INIT = 4'((WRITE_LATENCY >= 2) ? WRITE_LATENCY - 2 : 0);
  localparam logic [3:0] RD_CNT_INIT = 4'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

  if (WRITE_LATENCY < 1 || WRITE_LATENCY > 15) begin : g_bad_write_latency
    $error("WRITE_LATENCY must be in 1..15");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_read_latency
    $error("READ_LATENCY must be in 1..15");
  end

  typedef enum logic [2:0] {
    s_idle,
    s_write_wait,
    s_write_ack,
    s_read_wait,
    s_read_ack
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   mem_we;
  logic                   rd_load;
  logic [DATUM_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst_async) begin
    if (i_rst_async) begin
      state_q <= s_idle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write beats read when both arrive in idle; the read is simply lost.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    rd_load = 1'b0;
    case (state_q)
      s_idle: begin
        if (i_write_req) begin
          mem_we = 1'b1;
          if (WRITE_LATENCY == 1) begin
            state_d = s_write_ack;
          end else begin
            state_d = s_write_wait;
            cnt_d   = WR_CNT_INIT;
          end
        end else if (i_read_req) begin
          rd_load = 1'b1;
          if (READ_LATENCY == 1) begin
            state_d = s_read_ack;
          end else begin
            state_d = s_read_wait;
            cnt_d   = RD_CNT_INIT;
          end
        end
      end
      s_write_wait: begin
        if (cnt_q == 4'd0) state_d = s_write_ack;
        else               cnt_d   = cnt_q - 4'd1;
      end
      s_read_wait: begin
        if (cnt_q == 4'd0) state_d = s_read_ack;
        else               cnt_d   = cnt_q - 4'd1;
      end
      s_write_ack: state_d = s_idle;
      s_read_ack:  state_d = s_idle;
      default:     state_d = s_idle;
    endcase
  end

  // Array is deliberately not reset; the reset gate keeps a reset edge from committing a write.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst_async) begin
      mem[i_address] <= i_write_data & ~i_fault_mask;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst_async) begin
    if (i_rst_async) begin
      o_read_data <= '0;
    end else if (rd_load) begin
      o_read_data <= mem[i_address] & ~i_fault_mask;
    end
  end

  assign o_memory_write_ready = (state_q == s_write_ack);
  assign o_memory_read_valid  = (state_q == s_read_ack);
  assign o_busy               = (state_q != s_idle);

endmodule

// File: tb/tb_memtest_memory_responder.sv
// Bench for memtest_memory_responder: one instance at latencies 2/3, one at 1/1, checked against a word-array model.
module tb_memtest_memory_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr0, rd0, wr1, rd1;
  logic [3:0] addr;
  logic [7:0] wdata, mask;
  logic       wrdy0, rval0, busy0, wrdy1, rval1, busy1;
  logic [7:0] rdata0, rdata1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [2][16];
  bit         written   [2][16];
  logic [7:0] last_rd   [2];

  always #5 clk = ~clk;

  memtest_memory_responder #(.DATUM_WIDTH(8), .ADDR_WIDTH(4), .WRITE_LATENCY(2), .READ_LATENCY(3)) dut0 (
    .i_clk(clk), .i_rst_async(rst), .i_write_req(wr0), .i_read_req(rd0),
    .i_address(addr), .i_write_data(wdata), .i_fault_mask(mask),
    .o_memory_write_ready(wrdy0), .o_memory_read_valid(rval0),
    .o_read_data(rdata0), .o_busy(busy0)
  );

  memtest_memory_responder #(.DATUM_WIDTH(8), .ADDR_WIDTH(4), .WRITE_LATENCY(1), .READ_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst_async(rst), .i_write_req(wr1), .i_read_req(rd1),
    .i_address(addr), .i_write_data(wdata), .i_fault_mask(mask),
    .o_memory_write_ready(wrdy1), .o_memory_read_valid(rval1),
    .o_read_data(rdata1), .o_busy(busy1)
  );

  function automatic logic cur_wrdy(input int s);
    return (s != 0) ? wrdy1 : wrdy0;
  endfunction
  function automatic logic cur_rval(input int s);
    return (s != 0) ? rval1 : rval0;
  endfunction
  function automatic logic cur_busy(input int s);
    return (s != 0) ? busy1 : busy0;
  endfunction
  function automatic logic [7:0] cur_rdata(input int s);
    return (s != 0) ? rdata1 : rdata0;
  endfunction

  // One request on instance sel; every cycle until two past the ack is checked.
  task automatic do_op(input int sel, input bit wr, input bit rd, input logic [3:0] a,
                       input logic [7:0] d, input logic [7:0] m, input string name);
    int lat;
    lat = (sel != 0) ? 1 : (wr ? 2 : 3);
    @(negedge clk);
    checks++;
    if (cur_busy(sel) !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_before got=%b exp=0", name, cur_busy(sel));
    end
    addr = a; wdata = d; mask = m;
    if (sel != 0) begin wr1 = wr; rd1 = rd; end
    else          begin wr0 = wr; rd0 = rd; end
    @(posedge clk);
    if (wr) begin
      model_mem[sel][a] = d & ~m;
      written[sel][a]   = 1'b1;
    end else if (rd) begin
      last_rd[sel] = model_mem[sel][a] & ~m;
    end
    #1;
    wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
    addr = 4'($urandom); wdata = 8'($urandom); mask = 8'($urandom);
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      checks++;
      if (cur_wrdy(sel) !== (wr && c == lat)) begin
        failures++;
        $display("FAIL %s write_ready c=%0d got=%b exp=%b", name, c, cur_wrdy(sel), (wr && c == lat));
      end
      checks++;
      if (cur_rval(sel) !== (!wr && rd && c == lat)) begin
        failures++;
        $display("FAIL %s read_valid c=%0d got=%b exp=%b", name, c, cur_rval(sel), (!wr && rd && c == lat));
      end
      checks++;
      if (cur_rdata(sel) !== last_rd[sel]) begin
        failures++;
        $display("FAIL %s read_data c=%0d got=%h exp=%h", name, c, cur_rdata(sel), last_rd[sel]);
      end
      checks++;
      if (cur_busy(sel) !== (c <= lat)) begin
        failures++;
        $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, cur_busy(sel), (c <= lat));
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({wrdy0, rval0, busy0, rdata0, wrdy1, rval1, busy1, rdata1} !== 22'd0) begin
      failures++;
      $display("FAIL %s outputs got=%b_%b_%b_%h_%b_%b_%b_%h exp=all_zero", name,
               wrdy0, rval0, busy0, rdata0, wrdy1, rval1, busy1, rdata1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
    addr = '0; wdata = '0; mask = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < 16; i++) written[s][i] = 1'b0;
    #3;
    check_all_zero("reset_initial");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_latency();
    do_op(0, 1, 0, 4'd3, 8'hA5, 8'h00, "lat_write");
    do_op(0, 0, 1, 4'd3, 8'h00, 8'h00, "lat_read");
  endtask

  task automatic test_walking_ones();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] v;
        v = 8'h01 << i;
        do_op(s, 1, 0, 4'd0, v, 8'h00, "walk_wr");
        do_op(s, 0, 1, 4'd0, 8'($urandom), 8'h00, "walk_rd");
      end
    end
  endtask

  task automatic test_fault_injection();
    do_op(0, 1, 0, 4'd5, 8'h10, 8'h10, "fault_wr10");
    do_op(0, 0, 1, 4'd5, 8'h00, 8'h10, "fault_rd10");
    do_op(0, 1, 0, 4'd6, 8'hFF, 8'h10, "fault_wrFF");
    do_op(0, 0, 1, 4'd6, 8'h00, 8'h10, "fault_rdFF");
    do_op(0, 0, 1, 4'd6, 8'h00, 8'h00, "fault_stored");
  endtask

  task automatic test_simultaneous();
    do_op(0, 1, 1, 4'd8, 8'h3C, 8'h00, "simul_both");
    do_op(0, 0, 1, 4'd8, 8'h00, 8'h00, "simul_check");
    do_op(1, 1, 1, 4'd8, 8'hC3, 8'h00, "simul_both1");
    do_op(1, 0, 1, 4'd8, 8'h00, 8'h00, "simul_check1");
  endtask

  // Read held high during a write on the 2/3 instance: accepted at the first idle edge (k+3), valid in cycle 6.
  task automatic test_busy_read();
    logic [7:0] d, old_rd;
    d = 8'($urandom);
    @(negedge clk);
    addr = 4'd9; wdata = d; mask = 8'h00; wr0 = 1;
    @(posedge clk);
    model_mem[0][9] = d;
    written[0][9]   = 1'b1;
    old_rd = last_rd[0];
    #1;
    wr0 = 0; rd0 = 1; wdata = 8'($urandom);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checks++;
      if (wrdy0 !== (c == 2)) begin
        failures++;
        $display("FAIL busy_read write_ready c=%0d got=%b exp=%b", c, wrdy0, (c == 2));
      end
      checks++;
      if (rval0 !== (c == 6)) begin
        failures++;
        $display("FAIL busy_read read_valid c=%0d got=%b exp=%b", c, rval0, (c == 6));
      end
      checks++;
      if (rdata0 !== ((c >= 4) ? d : old_rd)) begin
        failures++;
        $display("FAIL busy_read read_data c=%0d got=%h exp=%h", c, rdata0, (c >= 4) ? d : old_rd);
      end
      checks++;
      if (busy0 !== (c <= 2 || (c >= 4 && c <= 6))) begin
        failures++;
        $display("FAIL busy_read busy c=%0d got=%b exp=%b", c, busy0, (c <= 2 || (c >= 4 && c <= 6)));
      end
      if (c == 3) begin
        @(posedge clk);
        #1;
        rd0 = 0;
      end
    end
    last_rd[0] = d;
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] v;
    v = 8'($urandom_range(1, 255));
    do_op(0, 1, 0, 4'd7, v, 8'h00, "rst_mid_wr");
    @(negedge clk);
    addr = 4'd7; mask = 8'h00; rd0 = 1;
    @(posedge clk);
    #1;
    rd0 = 0;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || rdata0 !== v) begin
      failures++;
      $display("FAIL rst_mid_pre busy/data got=%b/%h exp=1/%h", busy0, rdata0, v);
    end
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_immediate");
    last_rd[0] = '0; last_rd[1] = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rval0 !== 1'b0 || busy0 !== 1'b0 || rdata0 !== 8'h00) begin
        failures++;
        $display("FAIL rst_mid_after c=%0d rval/busy/data got=%b/%b/%h exp=0/0/00", c, rval0, busy0, rdata0);
      end
    end
    do_op(0, 0, 1, 4'd7, 8'h00, 8'h00, "rst_mid_reread");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int         s;
      logic [3:0] a;
      logic [7:0] m;
      s = int'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if (!written[s][a] || $urandom_range(0, 1) == 0)
        do_op(s, 1, ($urandom_range(0, 3) == 0), a, 8'($urandom), m, "rand_wr");
      else
        do_op(s, 0, 1, a, 8'($urandom), m, "rand_rd");
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_walking_ones();
    test_fault_injection();
    test_simultaneous();
    test_busy_read();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
